// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory responder and the stimulus master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    SKIP
  } spi_state_e;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for the SPI pins with sclk edge detection in the clk domain.
module spi_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic sdi_i,
  output logic rise_o,
  output logic fall_o,
  output logic cs_o,
  output logic sdi_o
);

  logic sclk_q, sclk_qq;
  logic cs_q, cs_qq;
  logic sdi_q, sdi_qq;

  // chip select resets deasserted so the responder starts out idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      cs_q    <= 1'b1;
      cs_qq   <= 1'b1;
      sdi_q   <= 1'b0;
      sdi_qq  <= 1'b0;
    end else begin
      sclk_q  <= sclk_i;
      sclk_qq <= sclk_q;
      cs_q    <= cs_i;
      cs_qq   <= cs_q;
      sdi_q   <= sdi_i;
      sdi_qq  <= sdi_q;
    end
  end

  assign rise_o = sclk_q & ~sclk_qq;
  assign fall_o = ~sclk_q & sclk_qq;
  assign cs_o   = cs_qq;
  assign sdi_o  = sdi_qq;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI responder: decodes cmd/addr/data frames into word memory requests and
// serializes read data back to the master.
module spi_slave_mem #(
  parameter int          DUMMY_CYCLES = 34,
  parameter logic [7:0]  CMD_WRITE    = spi_pkg::CMD_WRITE,
  parameter logic [7:0]  CMD_READ     = spi_pkg::CMD_READ,
  parameter logic [31:0] RD_FILL      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wr_done_o,
  output logic        rd_late_o
);
  import spi_pkg::*;

  logic        rise, fall, cs_s, sdi_s;
  spi_state_e  state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [30:0] sr;
  logic [31:0] frame_word, addr_r, rd_data, tx_sr;
  logic        is_rd, rd_rdy;
  logic        shift_en, cmd_done, addr_done, issue_rd, issue_wr, enter_rd;
  logic        p_vld, p_we;
  logic [31:0] p_addr, p_wdata;
  logic        new_req, new_we;
  logic [31:0] new_addr, new_wdata;

  spi_sync_edge u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sclk_i (spi_sclk_i),
    .cs_i   (spi_cs_i),
    .sdi_i  (spi_sdi_i),
    .rise_o (rise),
    .fall_o (fall),
    .cs_o   (cs_s),
    .sdi_o  (sdi_s)
  );

  assign frame_word = {sr, sdi_s};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // cs high overrides everything, including a coincident sclk rise
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    shift_en  = 1'b0;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    enter_rd  = 1'b0;
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_d = CMD;
          cnt_d   = 6'(CMD_BITS - 1);
        end
        CMD: if (rise) begin
          shift_en = 1'b1;
          if (cnt != '0) cnt_d = cnt - 6'd1;
          else if (frame_word[7:0] == CMD_WRITE || frame_word[7:0] == CMD_READ) begin
            cmd_done = 1'b1;
            state_d  = ADDR;
            cnt_d    = 6'(ADDR_BITS - 1);
          end else state_d = SKIP;
        end
        ADDR: if (rise) begin
          shift_en = 1'b1;
          if (cnt != '0) cnt_d = cnt - 6'd1;
          else begin
            addr_done = 1'b1;
            issue_rd  = is_rd;
            state_d   = is_rd ? DUMMY : WDATA;
            cnt_d     = is_rd ? 6'(DUMMY_CYCLES - 1) : 6'(DATA_BITS - 1);
          end
        end
        DUMMY: if (rise) begin
          if (cnt != '0) cnt_d = cnt - 6'd1;
          else begin
            enter_rd = 1'b1;
            state_d  = RDATA;
            cnt_d    = 6'(DATA_BITS - 1);
          end
        end
        RDATA: if (rise) begin
          if (cnt != '0) cnt_d = cnt - 6'd1;
          else begin
            state_d = CMD;
            cnt_d   = 6'(CMD_BITS - 1);
          end
        end
        WDATA: if (rise) begin
          shift_en = 1'b1;
          if (cnt != '0) cnt_d = cnt - 6'd1;
          else begin
            issue_wr = 1'b1;
            state_d  = CMD;
            cnt_d    = 6'(CMD_BITS - 1);
          end
        end
        SKIP:    state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr        <= '0;
      is_rd     <= 1'b0;
      addr_r    <= '0;
      rd_rdy    <= 1'b0;
      rd_data   <= '0;
      tx_sr     <= '0;
      spi_sdo_o <= 1'b0;
      rd_late_o <= 1'b0;
    end else begin
      if (shift_en)  sr     <= frame_word[30:0];
      if (cmd_done)  is_rd  <= (frame_word[7:0] == CMD_READ);
      if (addr_done) addr_r <= frame_word;
      if (issue_rd) rd_rdy <= 1'b0;
      else if (state == DUMMY && mem_rvalid_i) begin
        rd_rdy  <= 1'b1;
        rd_data <= mem_rdata_i;
      end
      // data that misses the end of DUMMY is replaced by the fill pattern
      if (enter_rd) begin
        if (mem_rvalid_i) tx_sr <= mem_rdata_i;
        else if (rd_rdy)  tx_sr <= rd_data;
        else begin
          tx_sr     <= RD_FILL;
          rd_late_o <= 1'b1;
        end
      end else if (state == RDATA && fall && !cs_s) begin
        spi_sdo_o <= tx_sr[31];
        tx_sr     <= {tx_sr[30:0], 1'b0};
      end
    end
  end

  assign spi_sdo_oe_o = (state == RDATA);

  assign new_req   = issue_rd | issue_wr;
  assign new_we    = issue_wr;
  assign new_addr  = issue_rd ? frame_word : addr_r;
  assign new_wdata = issue_wr ? frame_word : '0;

  // single pending slot absorbs a request that arrives while one is outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      p_vld       <= 1'b0;
      p_we        <= 1'b0;
      p_addr      <= '0;
      p_wdata     <= '0;
    end else begin
      if (mem_req_o) begin
        if (mem_gnt_i) mem_req_o <= 1'b0;
        if (cs_s)      p_vld     <= 1'b0;
      end else if (p_vld) begin
        p_vld <= 1'b0;
        if (!cs_s) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= p_we;
          mem_addr_o  <= p_addr;
          mem_wdata_o <= p_wdata;
        end
      end
      if (new_req) begin
        if (mem_req_o || p_vld) begin
          p_vld   <= 1'b1;
          p_we    <= new_we;
          p_addr  <= new_addr;
          p_wdata <= new_wdata;
        end else begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= new_we;
          mem_addr_o  <= new_addr;
          mem_wdata_o <= new_wdata;
        end
      end
    end
  end

  assign wr_done_o = mem_req_o & mem_we_o & mem_gnt_i;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Bench for spi_slave_mem: SPI master tasks, a memory responder and a
// transaction-level reference of expected requests and read data.
module tb_spi_slave_mem;
  import spi_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        sclk = 1'b0, cs = 1'b1, sdi = 1'b0;
  logic        sdo, sdo_oe, mem_req, mem_we, wr_done, rd_late;
  logic        mem_gnt = 1'b1, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int rd_delay = 2, wr_done_cnt = 0;
  logic        rv_pend = 1'b0;
  int          rv_wait = 0;
  logic [31:0] rv_data = '0;
  req_t        req_log[$];
  logic [31:0] mem [logic [31:0]];

  localparam logic [31:0] FILL = 32'hDEAD_BEEF;

  spi_slave_mem dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spi_sclk_i   (sclk),
    .spi_cs_i     (cs),
    .spi_sdi_i    (sdi),
    .spi_sdo_o    (sdo),
    .spi_sdo_oe_o (sdo_oe),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .wr_done_o    (wr_done),
    .rd_late_o    (rd_late)
  );

  always #5 clk = ~clk;

  // memory device: grant is tied high, so each request is visible for one negedge
  initial begin
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        rv_wait = rv_wait - 1;
        if (rv_wait <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pend    = 1'b0;
        end
      end
      if (mem_req) begin
        req_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
        else begin
          rv_pend = 1'b1;
          rv_wait = rd_delay;
          rv_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
      end
      if (wr_done) wr_done_cnt++;
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    sdi  = b;
    #60;
    r    = sdo;
    sclk = 1'b1;
    #60;
    sclk = 1'b0;
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n, output logic [31:0] r);
    logic b;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], b);
      r = {r[30:0], b};
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    spi_bits({24'h0, CMD_WRITE}, 8, r);
    spi_bits(addr, 32, r);
    spi_bits(data, 32, r);
  endtask

  task automatic spi_read_head(input logic [31:0] addr);
    logic [31:0] r;
    logic b;
    spi_bits({24'h0, CMD_READ}, 8, r);
    spi_bits(addr, 32, r);
    for (int i = 0; i < 34; i++) spi_bit(1'b0, b);
  endtask

  task automatic spi_read(input logic [31:0] addr, output logic [31:0] data);
    spi_read_head(addr);
    spi_bits(32'h0, 32, data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (sdo !== 1'b0)      begin n_fail++; $display("FAIL reset_sdo: got %b want 0", sdo); end
    n_chk++; if (sdo_oe !== 1'b0)   begin n_fail++; $display("FAIL reset_oe: got %b want 0", sdo_oe); end
    n_chk++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_chk++; if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_chk++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_chk++; if (wr_done !== 1'b0)  begin n_fail++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    n_chk++; if (rd_late !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_late: got %b want 0", rd_late); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    req_log.delete();
    wr_done_cnt = 0;
    cs_begin();
    spi_write(32'h0000_0064, 32'h0000_0064);
    cs_end();
    n_chk++; if (req_log.size() != 1) begin n_fail++; $display("FAIL write_count: got %0d want 1", req_log.size()); end
    if (req_log.size() > 0) begin
      n_chk++; if (req_log[0].we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", req_log[0].we); end
      n_chk++; if (req_log[0].addr !== 32'h64) begin n_fail++; $display("FAIL write_addr: got %h want 00000064", req_log[0].addr); end
      n_chk++; if (req_log[0].wdata !== 32'h64) begin n_fail++; $display("FAIL write_wdata: got %h want 00000064", req_log[0].wdata); end
    end
    n_chk++; if (wr_done_cnt != 1) begin n_fail++; $display("FAIL write_done_pulses: got %0d want 1", wr_done_cnt); end
  endtask

  task automatic test_read();
    logic [31:0] d;
    req_log.delete();
    mem[32'h64] = 32'h1234_5678;
    rd_delay = 2;
    cs_begin();
    spi_read(32'h64, d);
    cs_end();
    n_chk++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h want 12345678", d); end
    n_chk++; if (req_log.size() != 1) begin n_fail++; $display("FAIL read_count: got %0d want 1", req_log.size()); end
    if (req_log.size() > 0) begin
      n_chk++; if (req_log[0].we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b want 0", req_log[0].we); end
      n_chk++; if (req_log[0].addr !== 32'h64) begin n_fail++; $display("FAIL read_addr: got %h want 00000064", req_log[0].addr); end
    end
    n_chk++; if (rd_late !== 1'b0) begin n_fail++; $display("FAIL read_rd_late: got %b want 0", rd_late); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    req_log.delete();
    wr_done_cnt = 0;
    cs_begin();
    spi_write(32'h64, 32'hA5A5_A5A5);
    spi_read(32'h64, d);
    cs_end();
    n_chk++; if (d !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL b2b_data: got %h want a5a5a5a5", d); end
    n_chk++; if (req_log.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", req_log.size()); end
    if (req_log.size() == 2) begin
      n_chk++; if ({req_log[0].we, req_log[1].we} !== 2'b10) begin n_fail++; $display("FAIL b2b_order: got %b want 10", {req_log[0].we, req_log[1].we}); end
      n_chk++; if (req_log[1].addr !== 32'h64) begin n_fail++; $display("FAIL b2b_rd_addr: got %h want 00000064", req_log[1].addr); end
    end
    n_chk++; if (wr_done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", wr_done_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    bit          written [4];
    logic [31:0] ref_mem [logic [31:0]];
    req_t        exp_q[$];
    logic [31:0] d, v;
    int          k;
    req_log.delete();
    for (int i = 0; i < 4; i++) begin
      pool[i]    = {$urandom} | 32'h1_0000;
      written[i] = 1'b0;
    end
    cs_begin();
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 3);
      if (!written[k] || $urandom_range(0, 1) == 0) begin
        v = $urandom;
        spi_write(pool[k], v);
        ref_mem[pool[k]] = v;
        written[k] = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: pool[k], wdata: v});
      end else begin
        spi_read(pool[k], d);
        exp_q.push_back('{we: 1'b0, addr: pool[k], wdata: 32'h0});
        n_chk++;
        if (d !== ref_mem[pool[k]]) begin
          n_fail++; $display("FAIL rand_read_data[%0d]: got %h want %h", i, d, ref_mem[pool[k]]);
        end
      end
    end
    cs_end();
    n_chk++; if (req_log.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", req_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < req_log.size(); i++) begin
      n_chk++;
      if (req_log[i].we !== exp_q[i].we || req_log[i].addr !== exp_q[i].addr ||
          (exp_q[i].we && req_log[i].wdata !== exp_q[i].wdata)) begin
        n_fail++;
        $display("FAIL rand_req[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", i,
                 req_log[i].we, req_log[i].addr, req_log[i].wdata, exp_q[i].we, exp_q[i].addr, exp_q[i].wdata);
      end
    end
    n_chk++; if (rd_late !== 1'b0) begin n_fail++; $display("FAIL rand_rd_late: got %b want 0", rd_late); end
  endtask

  task automatic test_late_read();
    logic [31:0] d;
    mem[32'h200] = 32'h0BAD_F00D;
    rd_delay = 600;
    cs_begin();
    spi_read(32'h200, d);
    cs_end();
    n_chk++; if (d !== FILL) begin n_fail++; $display("FAIL late_data: got %h want %h", d, FILL); end
    n_chk++; if (rd_late !== 1'b1) begin n_fail++; $display("FAIL late_flag: got %b want 1", rd_late); end
    rd_delay = 2;
    cs_begin();
    spi_read(32'h200, d);
    cs_end();
    n_chk++; if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL late_next_data: got %h want 0badf00d", d); end
    n_chk++; if (rd_late !== 1'b1) begin n_fail++; $display("FAIL late_sticky: got %b want 1", rd_late); end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    req_log.delete();
    cs_begin();
    spi_bits({24'h0, CMD_WRITE}, 8, r);
    spi_bits(32'hFFFF_F000, 20, r);
    cs_end();
    n_chk++; if (req_log.size() != 0) begin n_fail++; $display("FAIL abort_no_req: got %0d want 0", req_log.size()); end
    cs_begin();
    spi_write(32'h0000_0300, 32'h1357_9BDF);
    cs_end();
    n_chk++; if (req_log.size() != 1) begin n_fail++; $display("FAIL abort_new_count: got %0d want 1", req_log.size()); end
    if (req_log.size() > 0) begin
      n_chk++; if (req_log[0].addr !== 32'h300) begin n_fail++; $display("FAIL abort_new_addr: got %h want 00000300", req_log[0].addr); end
      n_chk++; if (req_log[0].wdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL abort_new_wdata: got %h want 13579bdf", req_log[0].wdata); end
    end
  endtask

  task automatic test_skip();
    logic [31:0] r;
    req_log.delete();
    cs_begin();
    spi_bits(32'h55, 8, r);
    spi_bits({CMD_WRITE, 24'h0}, 32, r);
    spi_bits($urandom, 32, r);
    cs_end();
    n_chk++; if (req_log.size() != 0) begin n_fail++; $display("FAIL skip_no_req: got %0d want 0", req_log.size()); end
    cs_begin();
    spi_write(32'hC000_0004, 32'h2468_ACE0);
    cs_end();
    n_chk++; if (req_log.size() != 1) begin n_fail++; $display("FAIL skip_next_count: got %0d want 1", req_log.size()); end
    if (req_log.size() > 0) begin
      n_chk++; if (req_log[0].addr !== 32'hC000_0004) begin n_fail++; $display("FAIL skip_next_addr: got %h want c0000004", req_log[0].addr); end
      n_chk++; if (req_log[0].wdata !== 32'h2468_ACE0) begin n_fail++; $display("FAIL skip_next_wdata: got %h want 2468ace0", req_log[0].wdata); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    mem[32'h1000] = 32'hFFFF_FFFF;
    rd_delay = 2;
    cs_begin();
    spi_read_head(32'h1000);
    spi_bits(32'h0, 5, r);
    repeat (2) @(negedge clk);
    n_chk++; if (sdo_oe !== 1'b1) begin n_fail++; $display("FAIL mid_pre_oe: got %b want 1", sdo_oe); end
    n_chk++; if (r[4:0] !== 5'h1F) begin n_fail++; $display("FAIL mid_pre_bits: got %h want 1f", r[4:0]); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (sdo !== 1'b0)     begin n_fail++; $display("FAIL mid_sdo: got %b want 0", sdo); end
    n_chk++; if (sdo_oe !== 1'b0)  begin n_fail++; $display("FAIL mid_oe: got %b want 0", sdo_oe); end
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", mem_req); end
    n_chk++; if (rd_late !== 1'b0) begin n_fail++; $display("FAIL mid_rd_late: got %b want 0", rd_late); end
    rst = 1'b0;
    cs_end();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_late_read();
    test_abort();
    test_skip();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
SPI responder that sits at the other end of the stimulus SPI link, on the device side of the test setup. It deserializes command, address and data frames and turns them into word-wide memory write/read requests. For reads it serializes the returned word back on spi_sdo_o. Chip-select stays low across back-to-back transactions, so the block loops from DATA straight back to CMD.

Parameters:
DUMMY_CYCLES, 34, number of sclk cycles between the last address bit and the first read-data bit.
CMD_WRITE, 8'h02, opcode for a memory write.
CMD_READ, 8'h0B, opcode for a memory read.
RD_FILL, 32'hDEAD_BEEF, word shifted out when read data is not ready in time.

Ports:
clk_i  in  1  system clock; must run at least 4x the sclk frequency.
rst_i  in  1  reset, asynchronous, active-high.
spi_sclk_i  in  1  SPI clock from the master; idles low.
spi_cs_i  in  1  chip select, active-low.
spi_sdi_i  in  1  serial data from master (MOSI).
spi_sdo_o  out  1  serial data to master (MISO).
spi_sdo_oe_o  out  1  high while the read-data phase drives spi_sdo_o.
mem_req_o  out  1  memory request; held until grant.
mem_we_o  out  1  1 = write, 0 = read.
mem_addr_o  out  32  word address (byte address from the frame).
mem_wdata_o  out  32  write data.
mem_gnt_i  in  1  request accepted.
mem_rvalid_i  in  1  read data valid; one-cycle pulse.
mem_rdata_i  in  32  read data.
wr_done_o  out  1  one-cycle pulse when a write is granted.
rd_late_o  out  1  sticky: read data arrived after the data phase started; cleared by reset only.

Behaviour:
- Input sampling: sclk, cs and sdi each pass through a 2-flop synchronizer. rise = sclk_q & ~sclk_qq; fall is the complement.
- Bit sampling: sdi is sampled on rise. Frames are MSB first.
- Reset values: all outputs 0, state IDLE, shift/bit counters 0.
- Chip select: a synchronized cs high in any state forces IDLE on the next clk.
  - Aborts any un-issued request.
  - A request already asserted stays asserted until mem_gnt_i; no new request follows.
  - spi_sdo_oe_o deasserts.
- IDLE: on synchronized cs low go to CMD, bit counter = 7.
- CMD: shift 8 bits.
  - Opcode == CMD_WRITE or CMD_READ: go to ADDR, counter = 31.
  - Any other opcode: go to SKIP.
- ADDR: shift 32 bits into the address register.
  - Write: go to WDATA, counter = 31.
  - Read: assert mem_req_o with mem_we_o = 0 and mem_addr_o = addr in the same clk as the 32nd rise; go to DUMMY, counter = DUMMY_CYCLES-1.
- DUMMY: count rises.
  - Capture mem_rdata_i into the read register on mem_rvalid_i and set a ready flag.
  - After DUMMY_CYCLES rises go to RDATA, counter = 31.
- RDATA: spi_sdo_oe_o = 1.
  - Bit 31 is driven on the first fall after entering RDATA.
  - Each later fall shifts the next bit. sdo changes only on falls.
  - If ready is not set at entry, shift RD_FILL instead and set rd_late_o. A late rvalid is discarded.
  - After the 32nd rise return to CMD, counter = 7, oe = 0.
- WDATA: shift 32 bits.
  - On the 32nd rise assert mem_req_o with mem_we_o = 1, addr and wdata.
  - Return to CMD, counter = 7.
- Memory handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until the clk where mem_gnt_i = 1; req drops the next clk.
  - wr_done_o pulses in the grant clk of a write.
  - If a new request is due while the previous one is still un-granted, the new one is queued in a single-entry pending slot.
  - Frame spacing (8+32 sclk) guarantees no second overflow.
- SKIP: ignore sclk until cs goes high.
- Address width: all 32 address bits are taken from the frame; no truncation.
- Counters: 6-bit, decrement on rise, terminal at 0. There is no wrap-around; the state always changes at terminal.
- Simultaneous cs high and rise in the same clk: cs wins and the bit is discarded.

Decomposition:
- Shared package spi_pkg:
  - state enum IDLE/CMD/ADDR/DUMMY/RDATA/WDATA/SKIP.
  - CMD_WRITE and CMD_READ constants, also used by the stimulus master.
  - Frame-length constants CMD_BITS = 8, ADDR_BITS = 32, DATA_BITS = 32.
- One sub-module spi_sync_edge:
  - 2-flop synchronizer for sclk/cs/sdi.
  - Outputs rise/fall pulses and synchronized cs/sdi.
  - Instanced once.

Test Plan:
- Write frame: cmd 0x02, addr 0x00000064, data 0x00000064, gnt tied 1 → exactly one mem_req_o with we = 1, addr = 0x64, wdata = 0x64; wr_done_o pulses once.
- Read frame: cmd 0x0B, addr 0x64, 34 dummy cycles, memory returns 0x12345678 two clk after req → req with we = 0, addr = 0x64; master captures 0x12345678 on 32 rising edges; rd_late_o stays 0.
- Back-to-back with cs held low: write 0x64/0xA5A5A5A5 then read 0x64, memory model echoes → read returns 0xA5A5A5A5; two requests in order.
- Late read: rvalid withheld until after DUMMY ends → sdo shifts 0xDEADBEEF, rd_late_o = 1 and stays 1 through the next good read.
- Abort: cs raised after 20 address bits, then a fresh write frame → no request from the aborted frame; the new write is issued correctly.
- Unknown opcode 0x55 followed by 64 sclk, then cs high/low and a valid write → no request during the SKIP frame; the valid write is issued. Reset asserted mid-RDATA → all outputs 0 within one clk.
